line_buffer_3x3: RTL and testbench
==================================

Name: line_buffer_3x3

Overview:
- Streaming 3x3 sliding-window generator for CNN/convolution front ends.
- Accepts one pixel per valid cycle in raster order (row-major, top-left first) and buffers the two previous image lines in internal line memories.
- Emits the full 3x3 neighbourhood for every fully interior window position; no padding.
- Sits between a pixel source (with arbitrary idle gaps) and a 3x3 convolution/MAC stage.

Parameters:
- DATA_WIDTH  8  bits per pixel.
- WIDTH  5  pixels per image line; must be >= 3.
- HEIGHT  5  lines per frame; must be >= 3.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  pix_in is accepted on this clock edge.
- pix_in  input  DATA_WIDTH  input pixel, raster order.
- win_valid  output  1  window outputs hold a new valid window this cycle (one-cycle pulse per window).
- p00,p01,p02  output  DATA_WIDTH each  window top row (line r-2), columns c-2, c-1, c.
- p10,p11,p12  output  DATA_WIDTH each  window middle row (line r-1), columns c-2, c-1, c.
- p20,p21,p22  output  DATA_WIDTH each  window bottom row (line r, newest), columns c-2, c-1, c; p22 is the most recently accepted pixel.

Behaviour:
- Reset (rst_n=0, asynchronous): win_valid=0, all p** = 0, column counter=0, row counter=0. Line memory contents are not reset and need not be cleared; they are never exposed in a valid window.
- Counters: col (0..WIDTH-1) and row (0..HEIGHT-1) advance only on cycles with in_valid=1.
  - col wraps to 0 after WIDTH-1 and row increments.
  - After the pixel at (HEIGHT-1, WIDTH-1), both wrap to 0; the next accepted pixel is row 0, col 0 of a new frame.
  - No frame/line sync inputs exist; framing is purely by pixel count.
- Idle cycles (in_valid=0) of any length, inside a line, between lines, or between frames: all state frozen, win_valid=0, p** hold their last values.
- On an accepted pixel at (row, col):
  - Window shifts left one column: p00<=p01, p01<=p02, p10<=p11, p11<=p12, p20<=p21, p21<=p22.
  - New right column: p02<=line1[col] (pixel from line r-2), p12<=line0[col] (line r-1), p22<=pix_in.
  - Line memories update: line1[col]<=line0[col], line0[col]<=pix_in. Reads return old contents (read-before-write in the same cycle).
- win_valid is registered and asserts on the edge that accepts a pixel with row>=2 and col>=2. The window is visible the cycle after acceptance, so latency is 1 clock. It deasserts on the next edge unless another qualifying pixel is accepted.
- Windows per frame: (WIDTH-2)*(HEIGHT-2) = 9 at defaults. Positions with col<2 or row<2 never raise win_valid, even though the window registers still shift.
- Back-to-back qualifying pixels give consecutive win_valid cycles (full throughput, one window per pixel).
- Counter width: $clog2 of WIDTH and HEIGHT, minimum 1 bit. Pixel data passes through unmodified; no arithmetic.
- Reset asserted mid-frame: counters return to 0 immediately; the next accepted pixel is treated as (0,0) of a fresh frame. Stale line data must not produce a window before row 2, col 2 of the new frame.
- Implementation: line memories as arrays of WIDTH entries (inferred RAM or registers); all outputs driven directly from registers.

Test Plan:
- Single 5x5 frame, pixel value = row*5+col+1, 4 idle cycles after each line -> exactly 9 win_valid pulses.
  - First window: rows 1 2 3 / 6 7 8 / 11 12 13, one cycle after pixel 13 is accepted.
  - Last window: 13 14 15 / 18 19 20 / 23 24 25.
- Three consecutive frames (bases 0, 100, 200, value = base+row*5+col+1) separated by 20 idle cycles -> 27 windows total.
  - Frame 1 first window: 101 102 103 / 106 107 108 / 111 112 113.
  - Frame 2 last window: 213 214 215 / 218 219 220 / 223 224 225.
  - No cross-frame window.
- Continuous stream with no idle cycles, frame 0 -> windows for row 2 at col 2,3,4 appear on 3 consecutive cycles: (1 2 3/6 7 8/11 12 13), (2 3 4/7 8 9/12 13 14), (3 4 5/8 9 10/13 14 15).
- Randomly toggling in_valid within lines -> window sequence and values identical to the continuous case; p** stable while in_valid=0.
- Reset pulsed after row 2, col 3 of a frame, then a fresh frame sent -> all outputs 0 during reset. First window after release equals the fresh frame's (rows 0-2, cols 0-2) data, and exactly 9 windows follow.
- Post-reset, before any input -> win_valid=0, all p** = 0 indefinitely.

Source files
------------

// File: rtl/line_buffer_3x3.sv
// Streaming 3x3 window generator with two line memories.
// Emits one window per accepted interior pixel, latency one clock.
module line_buffer_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH      = 5,
  parameter int HEIGHT     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] pix_in,
  output logic                  win_valid,
  output logic [DATA_WIDTH-1:0] p00,
  output logic [DATA_WIDTH-1:0] p01,
  output logic [DATA_WIDTH-1:0] p02,
  output logic [DATA_WIDTH-1:0] p10,
  output logic [DATA_WIDTH-1:0] p11,
  output logic [DATA_WIDTH-1:0] p12,
  output logic [DATA_WIDTH-1:0] p20,
  output logic [DATA_WIDTH-1:0] p21,
  output logic [DATA_WIDTH-1:0] p22
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_line0 [WIDTH];
  logic [DATA_WIDTH-1:0] r_line1 [WIDTH];

  logic w_col_end;
  logic w_row_end;
  logic w_qual;

  assign w_col_end = (r_col == COL_LAST);
  assign w_row_end = (r_row == ROW_LAST);
  assign w_qual    = (r_row >= ROW_TWO) && (r_col >= COL_TWO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (in_valid) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Line memories hold stale data after reset; the row/col gate hides it.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_line1[r_col] <= r_line0[r_col];
      r_line0[r_col] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      p00 <= '0;
      p01 <= '0;
      p02 <= '0;
      p10 <= '0;
      p11 <= '0;
      p12 <= '0;
      p20 <= '0;
      p21 <= '0;
      p22 <= '0;
    end else begin
      win_valid <= in_valid && w_qual;
      if (in_valid) begin
        p00 <= p01;
        p01 <= p02;
        p02 <= r_line1[r_col];
        p10 <= p11;
        p11 <= p12;
        p12 <= r_line0[r_col];
        p20 <= p21;
        p21 <= p22;
        p22 <= pix_in;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_3x3.sv
// Testbench for line_buffer_3x3: image model feeds a window
// scoreboard; scenario table plus hand-written reset sequences.
module tb_line_buffer_3x3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] pix_in = 8'd0;
  logic       win_valid;
  logic [7:0] p00, p01, p02;
  logic [7:0] p10, p11, p12;
  logic [7:0] p20, p21, p22;

  line_buffer_3x3 #(
    .DATA_WIDTH(8),
    .WIDTH(5),
    .HEIGHT(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .pix_in(pix_in),
    .win_valid(win_valid),
    .p00(p00), .p01(p01), .p02(p02),
    .p10(p10), .p11(p11), .p12(p12),
    .p20(p20), .p21(p21), .p22(p22)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          base;
    int          nfr;
    int          gline;
    int          gframe;
    bit          rnd;
    bit          consec;
    int          exp_n;
    logic [71:0] first;
    logic [71:0] last;
    int          idx;
    logic [71:0] at_idx;
  } scen_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [71:0] sb[$];
  logic [7:0]  img[5][5];
  int          m_row = 0;
  int          m_col = 0;

  int          win_cnt = 0;
  logic [71:0] win_log[64];
  int          win_cyc[64];
  int          cyc = 0;
  logic        acc_q = 1'b0;
  logic        prev_rst = 1'b0;
  logic [71:0] snap = '0;

  wire [71:0] w_win = {p00, p01, p02,
                       p10, p11, p12,
                       p20, p21, p22};

  function automatic logic [71:0] w9(
    input int a, input int b, input int c,
    input int d, input int e, input int f,
    input int g, input int h, input int i);
    return {8'(a), 8'(b), 8'(c),
            8'(d), 8'(e), 8'(f),
            8'(g), 8'(h), 8'(i)};
  endfunction

  task automatic chk(input string nm,
                     input logic [71:0] got,
                     input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [71:0] mwin(input int r, input int c);
    return {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
            img[r-1][c-2], img[r-1][c-1], img[r-1][c],
            img[r][c-2],   img[r][c-1],   img[r][c]};
  endfunction

  task automatic model_acc(input logic [7:0] p);
    img[m_row][m_col] = p;
    if (m_row >= 2 && m_col >= 2)
      sb.push_back(mwin(m_row, m_col));
    if (m_col == 4) begin
      m_col = 0;
      m_row = (m_row == 4) ? 0 : m_row + 1;
    end else begin
      m_col = m_col + 1;
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] p);
    if (v) model_acc(p);
    in_valid = v;
    pix_in = p;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int base, input int gline,
                           input bit rnd);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (rnd) repeat ($urandom_range(0, 2)) drive(1'b0, 8'd0);
        drive(1'b1, 8'(base + r * 5 + c + 1));
      end
      repeat (gline) drive(1'b0, 8'd0);
    end
  endtask

  function automatic logic [71:0] logged(input int i);
    if (i < 0 || i >= win_cnt || i >= 64) return '0;
    return win_log[i];
  endfunction

  always @(posedge clk) begin
    acc_q <= in_valid;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (win_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_window: got %h expected none",
                 w_win);
      end else begin
        chk("window", w_win, sb.pop_front());
      end
      if (win_cnt < 64) begin
        win_log[win_cnt] = w_win;
        win_cyc[win_cnt] = cyc;
      end
      win_cnt++;
    end
    if (rst_n && prev_rst && !acc_q) begin
      chk("idle_valid", {71'b0, win_valid}, 72'b0);
      chk("idle_hold", w_win, snap);
    end
    snap = w_win;
    prev_rst = rst_n;
  end

  scen_t tbl[4];

  initial begin
    tbl[0] = '{0, 1, 4, 0, 1'b0, 1'b0, 9,
      w9(1, 2, 3, 6, 7, 8, 11, 12, 13),
      w9(13, 14, 15, 18, 19, 20, 23, 24, 25),
      0, w9(1, 2, 3, 6, 7, 8, 11, 12, 13)};
    tbl[1] = '{0, 3, 0, 20, 1'b0, 1'b0, 27,
      w9(1, 2, 3, 6, 7, 8, 11, 12, 13),
      w9(213, 214, 215, 218, 219, 220, 223, 224, 225),
      9, w9(101, 102, 103, 106, 107, 108, 111, 112, 113)};
    tbl[2] = '{0, 1, 0, 0, 1'b0, 1'b1, 9,
      w9(1, 2, 3, 6, 7, 8, 11, 12, 13),
      w9(13, 14, 15, 18, 19, 20, 23, 24, 25),
      1, w9(2, 3, 4, 7, 8, 9, 12, 13, 14)};
    tbl[3] = '{0, 1, 0, 0, 1'b1, 1'b0, 9,
      w9(1, 2, 3, 6, 7, 8, 11, 12, 13),
      w9(13, 14, 15, 18, 19, 20, 23, 24, 25),
      2, w9(3, 4, 5, 8, 9, 10, 13, 14, 15)};

    repeat (3) @(negedge clk);
    chk("reset_valid", {71'b0, win_valid}, 72'b0);
    chk("reset_win", w_win, 72'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) drive(1'b0, 8'd0);
    @(negedge clk);
    chk("post_reset_valid", {71'b0, win_valid}, 72'b0);
    chk("post_reset_win", w_win, 72'b0);

    for (int s = 0; s < 4; s++) begin
      win_cnt = 0;
      for (int f = 0; f < tbl[s].nfr; f++) begin
        run_frame(tbl[s].base + f * 100, tbl[s].gline,
                  tbl[s].rnd);
        repeat (tbl[s].gframe) drive(1'b0, 8'd0);
      end
      repeat (3) drive(1'b0, 8'd0);
      chk("win_count", 72'(win_cnt), 72'(tbl[s].exp_n));
      chk("sb_drained", 72'(sb.size()), 72'd0);
      chk("first_win", logged(0), tbl[s].first);
      chk("last_win", logged(win_cnt - 1), tbl[s].last);
      chk("idx_win", logged(tbl[s].idx), tbl[s].at_idx);
      if (tbl[s].consec && win_cnt >= 3) begin
        chk("consec_01", 72'(win_cyc[1] - win_cyc[0]), 72'd1);
        chk("consec_12", 72'(win_cyc[2] - win_cyc[1]), 72'd1);
      end
    end

    win_cnt = 0;
    for (int i = 0; i < 14; i++)
      drive(1'b1, 8'(50 + i + 1));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {71'b0, win_valid}, 72'b0);
    chk("mid_rst_win", w_win, 72'b0);
    chk("pre_rst_wins", 72'(win_cnt), 72'd2);
    chk("pre_rst_sb", 72'(sb.size()), 72'd0);
    m_row = 0;
    m_col = 0;
    repeat (2) @(negedge clk);
    chk("rst_hold_win", w_win, 72'b0);
    #2;
    rst_n = 1'b1;
    win_cnt = 0;
    run_frame(150, 0, 1'b0);
    repeat (3) drive(1'b0, 8'd0);
    chk("fresh_count", 72'(win_cnt), 72'd9);
    chk("fresh_first", logged(0),
        w9(151, 152, 153, 156, 157, 158, 161, 162, 163));
    chk("fresh_sb", 72'(sb.size()), 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
